cla_addsub_seq: RTL and testbench

//  Parametrised multi-cycle carry-lookahead adder/subtractor for the datapath ALU.
//  - Splits a WIDTH-bit operation into GROUP-bit CLA slices and evaluates one slice per clock.
//  - The carry passes between slices through a register.
//  - Uses the en/ready level handshake the sequencer already drives.
//  - Adds subtract mode and signed-overflow and zero flags.

---
 rtl/cla_addsub_seq.sv | 188 ++++++++++++++++++
 tb/tb_cla_addsub_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cla_addsub_seq.sv
// cla_addsub_seq: multi-cycle carry-lookahead adder/subtractor.
//   Splits a WIDTH-bit add/sub into NGROUPS = WIDTH/GROUP lookahead slices and
//   evaluates one slice per clock. The carry between slices is held in a register.
//   Uses an en/ready level handshake.
// Optional build macro: CLA_SINGLE_CYCLE_EN
//   When defined, all slices are chained combinationally and evaluated in one edge.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   en                  request level, held until ready
//   mode                0 = a+b+c_in, 1 = a-b-c_in (c_in is borrow-in)
//   a, b, c_in          operands, latched on the accepting edge
//   result              registered sum/difference
//   c_out, overflow     carry out of MSB (sub: 1 = no borrow), signed overflow
//   zero                result == 0
//   ready, busy         completion level, calculation in progress

// One GROUP-bit slice with full carry lookahead. p = a|b is a valid propagate
// term here because the sum bits are formed from a^b^c, not from p.
module cla_addsub_slice #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             c_out
);
  logic [GROUP-1:0] g, p;
  logic [GROUP:0]   c;
  logic             t;

  always_comb begin
    g = a & b;
    p = a | b;
    c = '0;
    t = 1'b0;
    c[0] = cin;
    for (int i = 1; i <= GROUP; i++) begin
      // carry-in term propagated through every lower bit
      t = cin;
      for (int k = 0; k < i; k++) t = t & p[k];
      c[i] = t;
      // generate at bit j propagated through bits j+1..i-1
      for (int j = 0; j < i; j++) begin
        t = g[j];
        for (int k = j + 1; k < i; k++) t = t & p[k];
        c[i] = c[i] | t;
      end
    end
  end

  assign s     = a ^ b ^ c[GROUP-1:0];
  assign c_out = c[GROUP];
endmodule

module cla_addsub_seq #(
  parameter int WIDTH = 8,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero,
  output logic             ready,
  output logic             busy
);
  localparam int NGROUPS = WIDTH / GROUP;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] a_r, b_r, full_sum;
  logic             carry_r, sum_cout, last, c_msb;

`ifdef CLA_SINGLE_CYCLE_EN
  logic [NGROUPS:0] ch;
  assign ch[0] = carry_r;
  for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_slice
    cla_addsub_slice #(.GROUP(GROUP)) u_slice (
      .a     (a_r[gi*GROUP +: GROUP]),
      .b     (b_r[gi*GROUP +: GROUP]),
      .cin   (ch[gi]),
      .s     (full_sum[gi*GROUP +: GROUP]),
      .c_out (ch[gi+1])
    );
  end
  assign sum_cout = ch[NGROUPS];
  assign last     = 1'b1;
`else
  localparam int IW = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  logic [IW-1:0]    idx_r;
  logic [WIDTH-1:0] psum_r;
  logic [GROUP-1:0] sl_a, sl_b, sl_s;

  always_comb begin
    sl_a = a_r[idx_r*GROUP +: GROUP];
    sl_b = b_r[idx_r*GROUP +: GROUP];
  end

  cla_addsub_slice #(.GROUP(GROUP)) u_slice (
    .a     (sl_a),
    .b     (sl_b),
    .cin   (carry_r),
    .s     (sl_s),
    .c_out (sum_cout)
  );

  // partial sum with the slice being evaluated this edge merged in
  always_comb begin
    full_sum = psum_r;
    full_sum[idx_r*GROUP +: GROUP] = sl_s;
  end

  assign last = (idx_r == IW'(NGROUPS - 1));
`endif

  // carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c
  assign c_msb = a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ full_sum[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = CALC;
      CALC:    if (!en) state_nxt = IDLE;
               else if (last) state_nxt = DONE;
      DONE:    if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == DONE);
    busy  = (state == CALC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      carry_r  <= 1'b0;
      result   <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
`ifndef CLA_SINGLE_CYCLE_EN
      idx_r    <= '0;
      psum_r   <= '0;
`endif
    end else begin
      if (state == IDLE && en) begin
        a_r     <= a;
        // subtract as a + ~b + 1, with borrow-in removing the +1
        b_r     <= mode ? ~b : b;
        carry_r <= c_in ^ mode;
`ifndef CLA_SINGLE_CYCLE_EN
        idx_r   <= '0;
        psum_r  <= '0;
`endif
      end
      // an abort (en low) leaves the previous completed outputs untouched
      if (state == CALC && en) begin
`ifndef CLA_SINGLE_CYCLE_EN
        psum_r  <= full_sum;
        carry_r <= sum_cout;
        idx_r   <= idx_r + 1'b1;
`endif
        if (last) begin
          result   <= full_sum;
          c_out    <= sum_cout;
          overflow <= c_msb ^ sum_cout;
          zero     <= (full_sum == '0);
        end
      end
    end
  end
endmodule

// File: tb/tb_cla_addsub_seq.sv
module tb_cla_addsub_seq;
`ifdef CLA_SINGLE_CYCLE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n, en, mode, c_in;
  logic [7:0] a, b, result;
  logic       c_out, overflow, zero, ready, busy;

  cla_addsub_seq #(.WIDTH(8), .GROUP(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .c_in(c_in),
    .result(result), .c_out(c_out), .overflow(overflow), .zero(zero),
    .ready(ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] res;
    logic       co, ov, z;
    int         latch;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: pops an expectation on every rising ready
  logic rdy_q = 1'b0;
  always @(negedge clk) begin
    if (ready && !rdy_q) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got result %0h with no request outstanding", result);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result",   {24'd0, result}, {24'd0, e.res});
        chk("c_out",    {31'd0, c_out},    {31'd0, e.co});
        chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
        chk("zero",     {31'd0, zero},     {31'd0, e.z});
        chk("latency",  cyc - e.latch, LAT);
      end
    end
    rdy_q = ready;
  end

  task automatic op(input logic [7:0] ai, input logic [7:0] bi, input logic m, input logic ci,
                    input logic [7:0] res, input logic co, input logic ov, input logic z,
                    input bit scramble);
    int n;
    @(negedge clk);
    a = ai; b = bi; mode = m; c_in = ci; en = 1'b1;
    sbq.push_back('{res, co, ov, z, cyc + 1});
    @(negedge clk);
    if (scramble) begin
      a = ~ai; b = 8'hFF; mode = ~m; c_in = ~ci;
    end
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: ready still 0 after %0d cycles, required 1", n);
    end
    // en held in DONE: outputs hold, no restart
    @(negedge clk);
    chk("hold_ready", {31'd0, ready}, 1);
    chk("hold_busy",  {31'd0, busy},  0);
    chk("hold_res",   {24'd0, result}, {24'd0, res});
    en = 1'b0;
    @(negedge clk);
    chk("drop_ready", {31'd0, ready}, 0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; c_in = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_result",   {24'd0, result},   0);
    chk("rst_c_out",    {31'd0, c_out},    0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    chk("rst_zero",     {31'd0, zero},     1);
    chk("rst_ready",    {31'd0, ready},    0);
    chk("rst_busy",     {31'd0, busy},     0);
    @(negedge clk);
    rst_n = 1'b1;

    op(8'h3C, 8'h15, 1'b0, 1'b0, 8'h51, 1'b0, 1'b0, 1'b0, 1'b0);
    op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    op(8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
    // carry-in rippling across the slice boundary
    op(8'h0F, 8'hF0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    // borrow-in
    op(8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    op(8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);

    // abort: en dropped one edge into CALC
    @(negedge clk);
    a = 8'h3C; b = 8'h15; mode = 1'b0; c_in = 1'b0; en = 1'b1;
    @(negedge clk);
    chk("abort_busy_on", {31'd0, busy}, 1);
    en = 1'b0;
    @(negedge clk);
    chk("abort_busy_off", {31'd0, busy},    0);
    chk("abort_ready",    {31'd0, ready},   0);
    chk("abort_result",   {24'd0, result},  8'h7F);
    chk("abort_overflow", {31'd0, overflow}, 1);
    @(negedge clk);
    chk("abort_ready2",   {31'd0, ready},   0);

    // inputs changed after the latch edge must not matter
    op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b1);

    // reset mid-CALC
    @(negedge clk);
    a = 8'h3C; b = 8'h15; mode = 1'b0; c_in = 1'b0; en = 1'b1;
    @(negedge clk);
    chk("rst2_busy_on", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("rst2_result",   {24'd0, result},   0);
    chk("rst2_c_out",    {31'd0, c_out},    0);
    chk("rst2_overflow", {31'd0, overflow}, 0);
    chk("rst2_zero",     {31'd0, zero},     1);
    chk("rst2_ready",    {31'd0, ready},    0);
    chk("rst2_busy",     {31'd0, busy},     0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    op(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end
endmodule
